// File: rtl/mem_pkg.sv
// Shared types and constants for the LSQ data memory and its response pipeline.
package mem_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    localparam logic LS_LOAD  = 1'b1;
    localparam logic LS_STORE = 1'b0;
    localparam logic BMS_BYTE = 1'b1;
    localparam logic BMS_WORD = 1'b0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              ls;
        logic              valid;
    } mem_resp_t;

    function automatic logic [DATA_W-1:0] sign_extend_byte(input logic [7:0] b);
        return {{(DATA_W-8){b[7]}}, b};
    endfunction

endpackage

// File: rtl/mem_resp_pipe.sv
// Fixed-latency response delay line; a synchronous clear drops every in-flight response.
module mem_resp_pipe
    import mem_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic      clk,
    input  logic      reset,
    input  mem_resp_t in_resp,
    output mem_resp_t out_resp
);

    mem_resp_t stages [LATENCY];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= in_resp;
            for (int i = 1; i < LATENCY; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign out_resp = stages[LATENCY-1];

endmodule

// File: rtl/memory.sv
// Byte-addressable data memory for the LSQ: word/byte loads and stores with a
// fixed-latency, in-order response that echoes the request address.
module memory
    import mem_pkg::*;
#(
    parameter int MEM_BYTES = 1024,
    parameter int LATENCY   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] store_value,
    input  logic              BMS,
    input  logic              LS,
    input  logic              valid,
    output logic [ADDR_W-1:0] addr_out,
    output logic [DATA_W-1:0] load_value_out,
    output logic              LS_out,
    output logic              valid_out
);

    localparam int IDX_W = $clog2(MEM_BYTES);

    logic [7:0] storage [MEM_BYTES] = '{default: 8'h00};

    logic [IDX_W-1:0] eff;
    logic [IDX_W-3:0] word_idx;
    logic             do_store;
    logic [DATA_W-1:0] word_data;
    logic [DATA_W-1:0] load_data;
    mem_resp_t         req_resp;
    mem_resp_t         pipe_out;

    assign eff      = address[IDX_W-1:0];
    assign word_idx = eff[IDX_W-1:2];
    assign do_store = valid && !reset && (LS == LS_STORE);

    // Storage is deliberately untouched by reset; only requests are gated by it.
    always_ff @(posedge clk) begin
        if (do_store) begin
            if (BMS == BMS_BYTE) begin
                storage[eff] <= store_value[7:0];
            end else begin
                storage[{word_idx, 2'd0}] <= store_value[7:0];
                storage[{word_idx, 2'd1}] <= store_value[15:8];
                storage[{word_idx, 2'd2}] <= store_value[23:16];
                storage[{word_idx, 2'd3}] <= store_value[31:24];
            end
        end
    end

    always_comb begin
        word_data = {storage[{word_idx, 2'd3}], storage[{word_idx, 2'd2}],
                     storage[{word_idx, 2'd1}], storage[{word_idx, 2'd0}]};
        load_data = (BMS == BMS_BYTE) ? sign_extend_byte(storage[eff]) : word_data;
    end

    // Idle cycles push an all-zero entry so the outputs read 0 whenever valid_out is low.
    always_comb begin
        req_resp = '0;
        if (valid) begin
            req_resp.valid = 1'b1;
            req_resp.addr  = address;
            req_resp.ls    = LS;
            req_resp.data  = (LS == LS_LOAD) ? load_data : '0;
        end
    end

    mem_resp_pipe #(
        .LATENCY(LATENCY)
    ) u_resp_pipe (
        .clk     (clk),
        .reset   (reset),
        .in_resp (req_resp),
        .out_resp(pipe_out)
    );

    assign addr_out       = pipe_out.addr;
    assign load_value_out = pipe_out.data;
    assign LS_out         = pipe_out.ls;
    assign valid_out      = pipe_out.valid;

endmodule

// File: tb/tb_memory.sv
// Self-checking bench for memory: directed table, reset-mid-flight sequence and
// randomized traffic compared against a byte-array reference model.
module tb_memory;
    import mem_pkg::*;

    localparam int MEM_BYTES = 1024;
    localparam int LATENCY   = 2;
    localparam int NVEC      = 20;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address;
    logic [31:0] store_value;
    logic        BMS;
    logic        LS;
    logic        valid;
    logic [31:0] addr_out;
    logic [31:0] load_value_out;
    logic        LS_out;
    logic        valid_out;

    memory #(
        .MEM_BYTES(MEM_BYTES),
        .LATENCY  (LATENCY)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .address       (address),
        .store_value   (store_value),
        .BMS           (BMS),
        .LS            (LS),
        .valid         (valid),
        .addr_out      (addr_out),
        .load_value_out(load_value_out),
        .LS_out        (LS_out),
        .valid_out     (valid_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] addr;
        logic [31:0] data;
        logic        ls;
    } exp_t;

    typedef struct {
        logic        v;
        logic        ls;
        logic        bms;
        logic [31:0] addr;
        logic [31:0] sv;
        logic        ev;
        logic [31:0] eaddr;
        logic [31:0] edata;
        logic        els;
    } vec_t;

    exp_t       exp_q[$];
    logic [7:0] ref_mem [MEM_BYTES];
    vec_t       tbl [NVEC];
    int         edge_count;
    int         checks;
    int         failures;

    function automatic vec_t mk(logic v, logic ls, logic bms, logic [31:0] a, logic [31:0] sv,
                                logic ev, logic [31:0] ea, logic [31:0] ed, logic el);
        vec_t r;
        r.v = v; r.ls = ls; r.bms = bms; r.addr = a; r.sv = sv;
        r.ev = ev; r.eaddr = ea; r.edata = ed; r.els = el;
        return r;
    endfunction

    function automatic logic [31:0] model_load(logic [31:0] a, logic bms);
        int unsigned eff;
        int unsigned base;
        int          val;
        eff  = a % MEM_BYTES;
        base = eff - (eff % 4);
        if (bms) begin
            val = int'(ref_mem[eff]);
            if (val >= 128) val = val - 256;
            return 32'(val);
        end
        return 32'(ref_mem[base]) + 32'(ref_mem[base+1]) * 256 +
               32'(ref_mem[base+2]) * 65536 + 32'(ref_mem[base+3]) * 16777216;
    endfunction

    task automatic model_store(input logic [31:0] a, input logic bms, input logic [31:0] sv);
        int unsigned eff;
        int unsigned base;
        eff  = a % MEM_BYTES;
        base = eff - (eff % 4);
        if (bms) begin
            ref_mem[eff] = 8'(sv % 256);
        end else begin
            for (int k = 0; k < 4; k++) begin
                ref_mem[base + k] = 8'((sv / (32'd1 << (8 * k))) % 256);
            end
        end
    endtask

    task automatic compare(input string name, input logic ev, input logic [31:0] ea,
                           input logic [31:0] ed, input logic el);
        checks++;
        if ({valid_out, addr_out, load_value_out, LS_out} !== {ev, ea, ed, el}) begin
            failures++;
            $display("[TB] FAIL %s @edge %0d: got valid=%0b addr=%h data=%h ls=%0b, expected valid=%0b addr=%h data=%h ls=%0b",
                     name, edge_count, valid_out, addr_out, load_value_out, LS_out, ev, ea, ed, el);
        end
    endtask

    // Drive one cycle of stimulus at the negedge, advance through the posedge, land on the next negedge.
    task automatic applyStimulus(input logic v, input logic ls, input logic bms,
                                 input logic [31:0] a, input logic [31:0] sv);
        exp_t e;
        valid = v; LS = ls; BMS = bms; address = a; store_value = sv;
        if (!reset && v) begin
            e.due  = edge_count + LATENCY;
            e.addr = a;
            e.ls   = ls;
            if (ls) begin
                e.data = model_load(a, bms);
            end else begin
                e.data = 32'd0;
                model_store(a, bms, sv);
            end
            exp_q.push_back(e);
        end
        @(posedge clk);
        edge_count++;
        if (reset) exp_q.delete();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name);
        logic        ev;
        logic [31:0] ea;
        logic [31:0] ed;
        logic        el;
        ev = 1'b0; ea = '0; ed = '0; el = 1'b0;
        if (exp_q.size() > 0 && exp_q[0].due == edge_count) begin
            ev = 1'b1;
            ea = exp_q[0].addr;
            ed = exp_q[0].data;
            el = exp_q[0].ls;
            void'(exp_q.pop_front());
        end
        compare(name, ev, ea, ed, el);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        edge_count = 0;
        for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'h00;

        // With LATENCY=2 each row's expected output is the response of the previous row.
        tbl[0]  = mk(1, 0, 0, 32'h10,  32'hDEADBEEF, 0, 32'h0,   32'h0,        0);
        tbl[1]  = mk(1, 1, 0, 32'h10,  32'h0,        1, 32'h10,  32'h0,        0);
        tbl[2]  = mk(1, 0, 1, 32'h11,  32'h00000080, 1, 32'h10,  32'hDEADBEEF, 1);
        tbl[3]  = mk(1, 1, 1, 32'h11,  32'h0,        1, 32'h11,  32'h0,        0);
        tbl[4]  = mk(1, 1, 0, 32'h10,  32'h0,        1, 32'h11,  32'hFFFFFF80, 1);
        tbl[5]  = mk(1, 1, 1, 32'h13,  32'h0,        1, 32'h10,  32'hDEAD80EF, 1);
        tbl[6]  = mk(1, 1, 0, 32'h12,  32'h0,        1, 32'h13,  32'hFFFFFFDE, 1);
        tbl[7]  = mk(1, 0, 0, 32'h420, 32'h12345678, 1, 32'h12,  32'hDEAD80EF, 1);
        tbl[8]  = mk(1, 1, 0, 32'h20,  32'h0,        1, 32'h420, 32'h0,        0);
        tbl[9]  = mk(0, 1, 1, 32'h55,  32'hFFFFFFFF, 1, 32'h20,  32'h12345678, 1);
        tbl[10] = mk(1, 0, 0, 32'h0,   32'd1,        0, 32'h0,   32'h0,        0);
        tbl[11] = mk(1, 0, 0, 32'h4,   32'd2,        1, 32'h0,   32'h0,        0);
        tbl[12] = mk(1, 0, 0, 32'h8,   32'd3,        1, 32'h4,   32'h0,        0);
        tbl[13] = mk(1, 0, 0, 32'hC,   32'd4,        1, 32'h8,   32'h0,        0);
        tbl[14] = mk(1, 1, 0, 32'h0,   32'h0,        1, 32'hC,   32'h0,        0);
        tbl[15] = mk(1, 1, 0, 32'h4,   32'h0,        1, 32'h0,   32'd1,        1);
        tbl[16] = mk(1, 1, 0, 32'h8,   32'h0,        1, 32'h4,   32'd2,        1);
        tbl[17] = mk(1, 1, 0, 32'hC,   32'h0,        1, 32'h8,   32'd3,        1);
        tbl[18] = mk(0, 0, 0, 32'h0,   32'h0,        1, 32'hC,   32'd4,        1);
        tbl[19] = mk(0, 0, 0, 32'h0,   32'h0,        0, 32'h0,   32'h0,        0);

        reset = 1'b1;
        valid = 1'b0; LS = 1'b0; BMS = 1'b0; address = '0; store_value = '0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 0, 0, 32'h0, 32'h0);
            compare("reset_state", 0, 32'h0, 32'h0, 0);
        end
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
            compare("idle", 0, 32'h0, 32'h0, 0);
        end

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(tbl[i].v, tbl[i].ls, tbl[i].bms, tbl[i].addr, tbl[i].sv);
            compare($sformatf("table[%0d]", i), tbl[i].ev, tbl[i].eaddr, tbl[i].edata, tbl[i].els);
            checkOutput($sformatf("table_model[%0d]", i));
        end

        // Reset one cycle after a load: the load never completes, and a store made under reset is ignored.
        applyStimulus(1, 1, 0, 32'h10, 32'h0);
        compare("rst_pre", 0, 32'h0, 32'h0, 0);
        reset = 1'b1;
        applyStimulus(1, 0, 0, 32'h10, 32'h0);
        compare("rst_drop", 0, 32'h0, 32'h0, 0);
        reset = 1'b0;
        applyStimulus(0, 0, 0, 32'h0, 32'h0);
        compare("rst_after", 0, 32'h0, 32'h0, 0);
        applyStimulus(1, 1, 0, 32'h10, 32'h0);
        compare("rst_quiet", 0, 32'h0, 32'h0, 0);
        applyStimulus(0, 0, 0, 32'h0, 32'h0);
        compare("rst_keep", 1, 32'h10, 32'hDEAD80EF, 1);
        exp_q.delete();

        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            reset = ($urandom_range(0, 49) == 0);
            a = ($urandom() & 32'hFFFF_FC00) | 32'($urandom_range(0, 63));
            applyStimulus($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), a, $urandom());
            checkOutput("random");
        end
        reset = 1'b0;
        for (int i = 0; i < LATENCY + 1; i++) begin
            applyStimulus(0, 0, 0, 32'h0, 32'h0);
            checkOutput("drain");
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain_empty: %0d responses still expected, required 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
